image_window_loader: RTL
========================

# image_window_loader

Upstream feeder for the convolution `top`. It accepts a raster stream of pixels over a valid/ready handshake and assembles them into the flat 5x5 `image` word consumed by `top`. It holds each completed window stable on its output until the consumer accepts it, and it checks frame framing with an end-of-frame marker. An optional second bank lets the next window load while the current one is held.

## Interface
Parameters:
- `PIX_W`, default 4: bits per pixel; matches the 4-bit filter/image element width of `top`.
- `ROWS`, default 5: window rows.
- `COLS`, default 5: window columns.
- Derived, not overridable: `NPIX` = ROWS*COLS (25) and `IMG_W` = PIX_W*NPIX (100).

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `reset`, input, 1: asynchronous, active-low reset; 0 resets the block.
- `in_valid`, input, 1: pixel present on `in_pixel`.
- `in_ready`, output, 1: block can accept a pixel this cycle.
- `in_pixel`, input, PIX_W: pixel value, raster order (row 0 col 0 first).
- `in_last`, input, 1: marks the final pixel of a frame.
- `out_valid`, output, 1: `image` holds a complete window.
- `out_ready`, input, 1: consumer accepts the window this cycle.
- `image`, output, IMG_W: the window. Pixel k (k = row*COLS + col) sits at bits [IMG_W-1-k*PIX_W -: PIX_W], so pixel 0 is in the MSB nibble.
- `frame_err`, output, 1: one-cycle pulse on a framing violation.

## Operation
- A pixel is accepted on a rising edge with `in_valid && in_ready`. It is written to slot `pix_cnt` of the write bank, and `pix_cnt` (range 0..NPIX-1) then increments.
- Write-side FSM:
  - IDLE (`pix_cnt`==0, a free bank is available): accepting a pixel moves to FILL.
  - FILL: accepting pixel NPIX-1 with `in_last`=1 marks the write bank FULL and clears `pix_cnt`. The next state is IDLE if another bank is free, otherwise WAIT.
  - WAIT: `in_ready`=0. When the consumer frees a bank, the next state is IDLE.
- Framing:
  - `in_last`=1 on any pixel with index < NPIX-1 pulses `frame_err`, discards the partial frame and clears `pix_cnt`.
  - Pixel NPIX-1 accepted with `in_last`=0 also pulses `frame_err` and discards the frame.
  - A discarded frame never raises `out_valid`.
- Read side:
  - `out_valid` = read bank is FULL.
  - On `out_valid && out_ready`, the read bank becomes EMPTY and the read pointer advances.
- `image` always drives the read bank. It is stable for as long as `out_valid` is high and `out_ready` is low.
- Simultaneous events: a frame completing and a window being consumed in the same cycle are both applied. Neither is lost, and bank state remains consistent.
- `in_ready` is a function of registered state only. It has no combinational path from `out_ready`.

## Timing
- Reset values (asserted asynchronously):
  - `out_valid`=0, `frame_err`=0, `image`=0.
  - `pix_cnt`=0, all banks EMPTY, pointers at 0.
  - `in_ready` is 0 while `reset`=0 and 1 in the first cycle after release.
- Latency: if the 25th pixel is accepted on edge N and the read bank was EMPTY, `out_valid`=1 and `image` is valid from just after edge N.
- Throughput with ping-pong: one pixel per cycle sustained, and back-to-back windows with no bubble.
- `frame_err` goes high just after the edge that accepted the offending pixel and stays high for exactly one cycle.
- Reset mid-frame discards all banked and partial data immediately.

## Configuration
- `IMG_LOADER_PINGPONG_EN` defined: two banks. A new frame can fill while the previous window is held. `in_ready` drops only when both banks are FULL.
- Not defined: one bank. `in_ready`=0 from the completing edge until the cycle after `out_valid && out_ready`. Throughput is then one window per NPIX+1 cycles minimum, assuming `out_ready` is held at 1.

## Test plan
- Frame load: release reset, then stream 25 pixels: pixel 0 = 2, pixel 23 = 2, all others 1, with `in_last` on pixel 24. Required: `image` = 100'h21111_11111_11111_11111_11121, and `out_valid` rises the cycle after the last accept.
- Backpressure: hold `out_ready`=0 and stream 75 pixels continuously.
  - With PINGPONG: 50 pixels accepted, then `in_ready`=0, with `image` still holding frame 1.
  - Without PINGPONG: 25 pixels accepted, then `in_ready`=0.
- Early `in_last` on pixel index 10: one-cycle `frame_err` pulse and no `out_valid`. A following clean 25-pixel frame loads correctly.
- Missing `in_last` on pixel index 24: `frame_err` pulses, `out_valid` stays 0 and `pix_cnt` returns to 0.
- Reset mid-frame: assert `reset`=0 after 12 pixels. Outputs return to their reset values at once. A fresh frame of all-3 pixels gives `image` = 100'h33333_33333_33333_33333_33333.
- Simultaneous events (PINGPONG, `out_ready`=1, continuous stream): `out_valid` stays high across the window boundary, and `image` switches to the next frame on the edge where the consume and the completion coincide.

Source files
------------

// File: rtl/image_window_loader_if.sv
// Handshake bundle between a raster pixel source, the window loader and the window consumer.
// Ports (signals):
//   in_valid/in_ready/in_pixel/in_last : pixel stream into the loader
//   out_valid/out_ready/image          : assembled window out of the loader
//   frame_err                          : one-cycle framing violation pulse
// master: the environment side (source + consumer); slave: the loader side.
interface image_window_loader_if #(
  parameter int unsigned PIX_W = 4,
  parameter int unsigned ROWS  = 5,
  parameter int unsigned COLS  = 5
);
  localparam int unsigned IMG_W = PIX_W * ROWS * COLS;

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [IMG_W-1:0] image;
  logic             frame_err;

  modport master (
    output in_valid, in_pixel, in_last, out_ready,
    input  in_ready, out_valid, image, frame_err
  );

  modport slave (
    input  in_valid, in_pixel, in_last, out_ready,
    output in_ready, out_valid, image, frame_err
  );
endinterface

// File: rtl/image_window_loader.sv
// Assembles a raster pixel stream into a flat ROWS x COLS window for the convolution core.
// Pixel k (k = row*COLS + col) lands at image[IMG_W-1-k*PIX_W -: PIX_W].
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : image_window_loader_if.slave (pixel stream in, window out, frame_err pulse)
// Build option: define IMG_LOADER_PINGPONG_EN for two banks (fill one while the other is held);
// otherwise a single bank is used.
module image_window_loader #(
  parameter int unsigned PIX_W = 4,
  parameter int unsigned ROWS  = 5,
  parameter int unsigned COLS  = 5
) (
  input logic                  clk,
  input logic                  reset,
  image_window_loader_if.slave bus
);
  localparam int unsigned NPIX  = ROWS * COLS;
  localparam int unsigned IMG_W = PIX_W * NPIX;
  localparam int unsigned CNT_W = $clog2(NPIX);
`ifdef IMG_LOADER_PINGPONG_EN
  localparam int unsigned NB = 2;
`else
  localparam int unsigned NB = 1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WAIT} state_t;

  state_t           state_q, state_n;
  logic             rdy_q, rdy_n;
  logic             valid_q, valid_n;
  logic             err_q, err_n;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_n;
  logic [NB-1:0]    full_q, full_n;
  logic             wr_ptr_q, wr_ptr_n;
  logic             rd_ptr_q, rd_ptr_n;
  logic [PIX_W-1:0] bank_q [NB][NPIX];

  logic             accept_c, consume_c, last_pix_c, complete_c;
  logic [IMG_W-1:0] image_c;

  // State, bank flags and pointers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      rdy_q     <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      pix_cnt_q <= '0;
      full_q    <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
    end else begin
      state_q   <= state_n;
      rdy_q     <= rdy_n;
      valid_q   <= valid_n;
      err_q     <= err_n;
      pix_cnt_q <= pix_cnt_n;
      full_q    <= full_n;
      wr_ptr_q  <= wr_ptr_n;
      rd_ptr_q  <= rd_ptr_n;
    end
  end

  // Pixel storage; reset clears banked data so image reads 0 immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < int'(NB); b++) begin
        for (int k = 0; k < int'(NPIX); k++) begin
          bank_q[b][k] <= '0;
        end
      end
    end else if (accept_c) begin
      bank_q[wr_ptr_q][pix_cnt_q] <= bus.in_pixel;
    end
  end

  // Next-state: write FSM, framing check, bank bookkeeping
  always_comb begin
    state_n    = state_q;
    pix_cnt_n  = pix_cnt_q;
    full_n     = full_q;
    wr_ptr_n   = wr_ptr_q;
    rd_ptr_n   = rd_ptr_q;
    err_n      = 1'b0;

    accept_c   = bus.in_valid && rdy_q;
    consume_c  = full_q[rd_ptr_q] && bus.out_ready;
    last_pix_c = (pix_cnt_q == CNT_W'(NPIX - 1));
    complete_c = accept_c && last_pix_c && bus.in_last;

    if (accept_c) begin
      if (bus.in_last != last_pix_c) begin
        err_n     = 1'b1;
        pix_cnt_n = '0;
      end else if (complete_c) begin
        pix_cnt_n = '0;
      end else begin
        pix_cnt_n = pix_cnt_q + CNT_W'(1);
      end
    end

    // Consume and completion may coincide; both are applied to distinct banks
    if (consume_c) begin
      full_n[rd_ptr_q] = 1'b0;
      rd_ptr_n         = (NB > 1) ? ~rd_ptr_q : 1'b0;
    end
    if (complete_c) begin
      full_n[wr_ptr_q] = 1'b1;
      wr_ptr_n         = (NB > 1) ? ~wr_ptr_q : 1'b0;
    end

    case (state_q)
      S_IDLE: if (accept_c && !err_n) state_n = S_FILL;
      S_FILL: begin
        if (complete_c)  state_n = full_n[wr_ptr_n] ? S_WAIT : S_IDLE;
        else if (err_n)  state_n = S_IDLE;
      end
      S_WAIT: if (!full_n[wr_ptr_n]) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Ready comes from registered state only, no path from out_ready
    rdy_n   = (state_n != S_WAIT);
    valid_n = full_n[rd_ptr_n];
  end

  // Read bank flattened, pixel 0 in the most significant slot
  always_comb begin
    image_c = '0;
    for (int k = 0; k < int'(NPIX); k++) begin
      image_c[IMG_W-1-k*PIX_W -: PIX_W] = bank_q[rd_ptr_q][k];
    end
  end

  assign bus.in_ready  = rdy_q;
  assign bus.out_valid = valid_q;
  assign bus.frame_err = err_q;
  assign bus.image     = image_c;
endmodule
